// File: rtl/lib_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the LSU state encoding, funct3 codes and the legality check.
package lib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal funct3 for the direction and naturally aligned for its size.
  function automatic logic lsu_ok(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lane
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B):  ok = 1'b1;
      (f3 == F3_H):  ok = ~lane[0];
      (f3 == F3_W):  ok = (lane == 2'b00);
      (f3 == F3_BU): ok = ~we;
      (f3 == F3_HU): ok = ~we & ~lane[0];
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replication,
// plus load extraction with sign or zero extension.
module lsu_align
  import lib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rword,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata_o,
  output logic [WIDTH-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be      = 4'b0000;
    wdata_o = wdata;
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        be      = 4'b0001 << lane;
        wdata_o = {4{wdata[7:0]}};
      end
      (funct3[1:0] == 2'b01): begin
        be      = 4'b0011 << lane;
        wdata_o = {2{wdata[15:0]}};
      end
      (funct3[1:0] == 2'b10): be = 4'b1111;
      default:                be = 4'b0000;
    endcase
  end

  always_comb begin
    byte_sel = 8'(rword >> {lane, 3'b000});
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
    rdata_o  = rword;
    unique case (1'b1)
      (funct3 == F3_B):
        rdata_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      (funct3 == F3_BU):
        rdata_o = {{(WIDTH-8){1'b0}}, byte_sel};
      (funct3 == F3_H):
        rdata_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
      (funct3 == F3_HU):
        rdata_o = {{(WIDTH-16){1'b0}}, half_sel};
      default: rdata_o = rword;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit after MEM: runs one access on the data bus
// with req/gnt and rvalid handshakes, stalling until DONE.
module lsu_bus
  import lib_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [DADDR-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic             access_err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DADDR-3:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [DADDR-3:0] addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [3:0]       st_be;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] st_rd_unused;
  logic [3:0]       ld_be_unused;
  logic [WIDTH-1:0] ld_wd_unused;
  logic [WIDTH-1:0] ld_data;
  logic             ok;

  lsu_align #(.WIDTH(WIDTH)) u_st_align (
    .funct3  (req_funct3),
    .lane    (req_addr[1:0]),
    .wdata   (req_wdata),
    .rword   ({WIDTH{1'b0}}),
    .be      (st_be),
    .wdata_o (st_wdata),
    .rdata_o (st_rd_unused)
  );

  lsu_align #(.WIDTH(WIDTH)) u_ld_align (
    .funct3  (f3_q),
    .lane    (lane_q),
    .wdata   ({WIDTH{1'b0}}),
    .rword   (mem_rdata),
    .be      (ld_be_unused),
    .wdata_o (ld_wd_unused),
    .rdata_o (ld_data)
  );

  assign ok = lsu_ok(req_we, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    lane_d     = lane_q;
    rdata_d    = rdata_q;
    stall      = 1'b0;
    access_err = 1'b0;
    mem_req    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && ok) begin
          stall   = 1'b1;
          we_d    = req_we;
          addr_d  = req_addr[DADDR-1:2];
          be_d    = st_be;
          wdata_d = st_wdata;
          f3_d    = req_funct3;
          lane_d  = req_addr[1:0];
          state_d = REQ;
        end else if (req_valid) begin
          access_err = 1'b1;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = req_valid;
        if (mem_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = req_valid;
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: stores, loads, errors,
// reset mid-access and back-to-back requests.
module tb_lsu_bus;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        access_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errs = 0;
  int checks = 0;
  int issues = 0;
  logic [31:0] bus_word = 32'h0;

  lsu_bus #(.WIDTH(32), .DADDR(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .access_err (access_err),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      issues = issues + 1;
      if (mem_we) bus_word = mem_wdata;
    end
  end

  task automatic test_reset();
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 10'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata,
         stall, access_err} !== 80'h0) begin
      errs++;
      $display("FAIL reset: got req=%b we=%b addr=%h be=%b wd=%h rd=%h st=%b err=%b want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata,
               stall, access_err);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_store(input string name, input logic [2:0] f3,
                            input logic [9:0] addr, input logic [31:0] wd,
                            input int delay, input logic [3:0] ebe,
                            input logic [31:0] ewd);
    logic [7:0] ea;
    ea = addr[9:2];
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    checks++;
    if (stall !== 1'b1 || access_err !== 1'b0) begin
      errs++;
      $display("FAIL %s accept: stall=%b err=%b want 1/0", name, stall, access_err);
    end
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      mem_gnt = (i == delay);
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall} !==
          {1'b1, 1'b1, ea, ebe, ewd, 1'b1}) begin
        errs++;
        $display("FAIL %s req%0d: req=%b we=%b addr=%h be=%b wd=%h st=%b want 1 1 %h %b %h 1",
                 name, i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall,
                 ea, ebe, ewd);
      end
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errs++;
      $display("FAIL %s done: stall=%b req=%b want 0/0", name, stall, mem_req);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_load(input string name, input logic [2:0] f3,
                           input logic [9:0] addr, input logic [31:0] word,
                           input int gap, input logic [31:0] exp);
    logic [7:0] ea;
    ea = addr[9:2];
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = f3;
    req_addr   = addr;
    mem_rdata  = 32'h12345678;
    #1;
    checks++;
    if (stall !== 1'b1 || access_err !== 1'b0) begin
      errs++;
      $display("FAIL %s accept: stall=%b err=%b want 1/0", name, stall, access_err);
    end
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, ea}) begin
      errs++;
      $display("FAIL %s req: req=%b we=%b addr=%h want 1 0 %h",
               name, mem_req, mem_we, mem_addr, ea);
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 1; i < gap; i++) begin
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b1) begin
        errs++;
        $display("FAIL %s wait: req=%b stall=%b want 0/1", name, mem_req, stall);
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h12345678;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL %s done stall: got %b want 0", name, stall);
    end
    checks++;
    if (rdata !== exp) begin
      errs++;
      $display("FAIL %s rdata: got %h want %h", name, rdata, exp);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_illegal(input string name, input logic we,
                              input logic [2:0] f3, input logic [9:0] addr);
    int start;
    start = issues;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    #1;
    checks++;
    if (access_err !== 1'b1 || stall !== 1'b0) begin
      errs++;
      $display("FAIL %s err: err=%b stall=%b want 1/0", name, access_err, stall);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
        errs++;
        $display("FAIL %s bus: mem_req=%b want 0", name, mem_req);
      end
    end
    req_valid = 1'b0;
    #1;
    checks++;
    if (access_err !== 1'b0) begin
      errs++;
      $display("FAIL %s err_idle: err=%b want 0", name, access_err);
    end
    checks++;
    if (issues !== start) begin
      errs++;
      $display("FAIL %s issues: got %0d want %0d", name, issues, start);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 10'h001;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      errs++;
      $display("FAIL rstmid wait: req=%b stall=%b want 0/1", mem_req, stall);
    end
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({stall, mem_req, rdata} !== 34'h0) begin
      errs++;
      $display("FAIL rstmid clear: stall=%b req=%b rdata=%h want 0 0 0",
               stall, mem_req, rdata);
    end
    @(negedge clk);
    reset_n    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if ({stall, mem_req, rdata} !== 34'h0) begin
      errs++;
      $display("FAIL rstmid stray: stall=%b req=%b rdata=%h want 0 0 0",
               stall, mem_req, rdata);
    end
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 10'h004;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL rstmid idle: stall=%b want 1", stall);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int start;
    start = issues;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 10'h010;
    req_wdata  = 32'hDEADBEEF;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    req_we  = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errs++;
      $display("FAIL b2b done: stall=%b req=%b want 0/0", stall, mem_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errs++;
      $display("FAIL b2b accept: stall=%b req=%b want 1/0", stall, mem_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h04) begin
      errs++;
      $display("FAIL b2b ld req: req=%b we=%b addr=%h want 1 0 04",
               mem_req, mem_we, mem_addr);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = bus_word;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'hDEADBEEF || stall !== 1'b0) begin
      errs++;
      $display("FAIL b2b rdata: got %h stall=%b want deadbeef 0", rdata, stall);
    end
    req_valid = 1'b0;
    checks++;
    if (issues - start !== 2) begin
      errs++;
      $display("FAIL b2b issues: got %0d want 2", issues - start);
    end
  endtask

  initial begin
    test_reset();
    test_store("sw", 3'b010, 10'h104, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF);
    test_store("sb", 3'b000, 10'h0A3, 32'h000000AB, 3, 4'b1000, 32'hABABABAB);
    test_store("sh", 3'b001, 10'h012, 32'h1234CAFE, 1, 4'b1100, 32'hCAFECAFE);
    test_load("lb", 3'b000, 10'h002, 32'h0080FF00, 2, 32'hFFFFFF80);
    test_load("lbu", 3'b100, 10'h002, 32'h0080FF00, 2, 32'h00000080);
    test_load("lhu", 3'b101, 10'h002, 32'h0080FF00, 2, 32'h00000080);
    test_load("lh", 3'b001, 10'h000, 32'h0080FF00, 1, 32'hFFFFFF00);
    test_load("lw", 3'b010, 10'h008, 32'hA5A55A5A, 3, 32'hA5A55A5A);
    test_illegal("lw_mis", 1'b0, 3'b010, 10'h006);
    test_illegal("sh_f3", 1'b1, 3'b101, 10'h000);
    test_illegal("f3_011", 1'b0, 3'b011, 10'h000);
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
